me_window_feeder: RTL and testbench

//  - Writer side of the motion-estimation pixel shift chain. It takes 128-bit reference-row words
//    (16 pixels, pixel 0 in bits [7:0]) from the memory read path over a valid/ready handshake.
//  - It presents a 56-bit, 7-pixel lookahead window (oldest pixel in bits [7:0]) to the window

---
 rtl/me_window_feeder.sv | 145 ++++++++++++++
 tb/tb_me_window_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/me_window_feeder.sv
// Writer side of the motion-estimation pixel shift chain: 16-pixel words in, 7-pixel sliding window out.
// Define ME_FEED_PAD_EN to pad the row end with the final pixel instead of flushing the last window.
module me_window_feeder #(
    parameter int PIX_W   = 8,
    parameter int IN_PIX  = 16,
    parameter int OUT_PIX = 7,
    parameter int BUF_PIX = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    input  logic [PIX_W*IN_PIX-1:0]         in_data_i,
    input  logic                            in_last_i,
    input  logic                            adv_i,
    output logic                            out_valid_o,
    output logic [PIX_W*OUT_PIX-1:0]        out_data_o,
    output logic                            out_last_o,
    output logic [$clog2(BUF_PIX+1)-1:0]    level_o
);

    localparam int LVL_W = $clog2(BUF_PIX + 1);
    localparam int BUF_W = PIX_W * BUF_PIX;
    localparam int IN_W  = PIX_W * IN_PIX;
    localparam int OUT_W = PIX_W * OUT_PIX;

    localparam logic [LVL_W-1:0] L_IN   = LVL_W'(IN_PIX);
    localparam logic [LVL_W-1:0] L_OUT  = LVL_W'(OUT_PIX);
    localparam logic [LVL_W-1:0] L_ROOM = LVL_W'(BUF_PIX - IN_PIX);
`ifdef ME_FEED_PAD_EN
    localparam logic [LVL_W-1:0] L_TAIL_MIN = LVL_W'(1);
`else
    localparam logic [LVL_W-1:0] L_TAIL_MIN = LVL_W'(OUT_PIX);
`endif
    localparam logic [BUF_W-1:0] WORD_MASK = {{(BUF_W-IN_W){1'b0}}, {IN_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        TAIL   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [BUF_W-1:0]   r_buf;
    logic [BUF_W-1:0]   w_buf_next;
    logic [BUF_W-1:0]   w_buf_shift;
    logic [BUF_W-1:0]   w_word_ext;
    logic [BUF_W-1:0]   w_word_mask;
    logic [LVL_W-1:0]   r_level;
    logic [LVL_W-1:0]   w_level_next;
    logic [LVL_W-1:0]   w_level_shift;
    logic               w_acc;
    logic               w_adv;
    logic               w_flush;
    logic               w_row_end;

    assign w_acc     = in_valid_i && in_ready_o;
    assign w_adv     = adv_i && out_valid_o;
    assign w_row_end = (r_state == TAIL) && w_adv && (r_level == L_TAIL_MIN);

`ifdef ME_FEED_PAD_EN
    logic [PIX_W-1:0]   r_last_pix;

    // With padding the row drains pixel by pixel, so nothing is flushed.
    assign w_flush = 1'b0;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_pix <= '0;
        end else if (w_acc && in_last_i) begin
            r_last_pix <= in_data_i[IN_W-1 -: PIX_W];
        end
    end
`else
    assign w_flush = w_row_end;
`endif

    // Advance shifts first; the accepted word then lands right after the surviving pixels.
    assign w_level_shift = r_level - LVL_W'(w_adv);
    assign w_buf_shift   = w_adv ? (r_buf >> PIX_W) : r_buf;
    assign w_word_ext    = BUF_W'(in_data_i) << (w_level_shift * PIX_W);
    assign w_word_mask   = WORD_MASK << (w_level_shift * PIX_W);

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path infers a latch.
        w_buf_next   = w_buf_shift;
        w_level_next = w_level_shift;
        if (w_acc) begin
            w_buf_next   = (w_buf_shift & ~w_word_mask) | w_word_ext;
            w_level_next = w_level_shift + L_IN;
        end
        if (w_flush) begin
            w_buf_next   = '0;
            w_level_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: the pixel buffer is plain flops, so reset clears it like any other register.
        if (!rst_n_i) begin
            r_buf   <= '0;
            r_level <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register see pre-edge values.
            r_buf   <= w_buf_next;
            r_level <= w_level_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_acc) w_state_next = in_last_i ? TAIL : STREAM;
            STREAM:  if (w_acc && in_last_i) w_state_next = TAIL;
            TAIL:    if (w_row_end) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (r_state != TAIL) && (r_level <= L_ROOM);
        out_valid_o = (r_state == TAIL) ? (r_level >= L_TAIL_MIN) : (r_level >= L_OUT);
        out_last_o  = (r_state == TAIL) && (r_level == L_TAIL_MIN);
        level_o     = r_level;
        out_data_o  = r_buf[OUT_W-1:0];
`ifdef ME_FEED_PAD_EN
        // Positions past the last buffered pixel repeat the row's final pixel.
        for (int i = 0; i < OUT_PIX; i++) begin
            if ((r_state == TAIL) && (LVL_W'(i) >= r_level)) begin
                out_data_o[i*PIX_W +: PIX_W] = r_last_pix;
            end
        end
`endif
    end

endmodule

// File: tb/tb_me_window_feeder.sv
// Scoreboard bench for me_window_feeder: directed rows, expected windows queued per advance.
// Pixel value equals its position in the stream, so a window is fully defined by its first pixel.
module tb_me_window_feeder;

`ifdef ME_FEED_PAD_EN
    localparam int TAIL_MIN = 1;
`else
    localparam int TAIL_MIN = 7;
`endif

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         in_last_i;
    logic         adv_i;
    logic         out_valid_o;
    logic [55:0]  out_data_o;
    logic         out_last_o;
    logic [5:0]   level_o;

    typedef struct {
        logic [55:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    me_window_feeder dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .adv_i       (adv_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [55:0] win(input int first, input int lim);
        logic [55:0] w;
        int          p;
        for (int i = 0; i < 7; i++) begin
            p = first + i;
            if (p > lim) p = lim;
            w[i*8 +: 8] = 8'(p);
        end
        return w;
    endfunction

    function automatic logic [127:0] word(input int base);
        logic [127:0] w;
        for (int i = 0; i < 16; i++) w[i*8 +: 8] = 8'(base + i);
        return w;
    endfunction

    // Called just after a rising edge; holds the inputs for exactly one edge.
    task automatic step(input bit v, input logic [127:0] d, input bit l, input bit a);
        in_valid_i = v;
        in_data_i  = d;
        in_last_i  = l;
        adv_i      = a;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        adv_i      = 1'b0;
    endtask

    task automatic send(input int base, input bit l);
        step(1'b1, word(base), l, 1'b0);
    endtask

    task automatic adv_one(input int first, input int lim, input bit last);
        sb_q.push_back('{win(first, lim), last});
        step(1'b0, '0, 1'b0, 1'b1);
    endtask

    // Advance through the rest of a row that is already in TAIL.
    task automatic drain(input int first, input int lim, input int start_level);
        for (int k = 0; k <= start_level - TAIL_MIN; k++)
            adv_one(first + k, lim, (start_level - k) == TAIL_MIN);
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i && adv_i && out_valid_o) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL window: unexpected window %0h consumed, none expected", out_data_o);
            end else begin
                mon_e = sb_q.pop_front();
                check("window_data", out_data_o, mon_e.data);
                check("window_last", out_last_o, mon_e.last);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst_n_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        in_last_i  = 1'b0;
        adv_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        check("rst_level", level_o, 0);
        check("rst_ready", in_ready_o, 1);
        check("rst_valid", out_valid_o, 0);
        check("rst_data", out_data_o, 0);
        check("rst_last", out_last_o, 0);

        // Single-word row.
        send(8'h00, 1'b1);
        check("t1_level", level_o, 16);
        check("t1_ready_tail", in_ready_o, 0);
        check("t1_first", out_data_o, 56'h06050403020100);
        for (int k = 0; k < 16 - TAIL_MIN; k++) adv_one(k, 15, 1'b0);
        check("t1_end_data", out_data_o, (TAIL_MIN == 1) ? 56'h0F0F0F0F0F0F0F : 56'h0F0E0D0C0B0A09);
        check("t1_end_last", out_last_o, 1);
        adv_one(16 - TAIL_MIN, 15, 1'b1);
        check("t1_idle_level", level_o, 0);
        check("t1_idle_valid", out_valid_o, 0);
        check("t1_idle_ready", in_ready_o, 1);

        // Fill to capacity, drain half, third word waits for room.
        send(8'h20, 1'b0);
        check("t2_ready_16", in_ready_o, 1);
        send(8'h30, 1'b0);
        check("t2_full_level", level_o, 32);
        check("t2_full_ready", in_ready_o, 0);
        for (int k = 0; k < 15; k++) adv_one(8'h20 + k, 8'h4F, 1'b0);
        sb_q.push_back('{win(8'h2F, 8'h4F), 1'b0});
        step(1'b1, word(8'h40), 1'b1, 1'b1);
        check("t2_half_level", level_o, 16);
        check("t2_half_ready", in_ready_o, 1);
        send(8'h40, 1'b1);
        check("t2_third_level", level_o, 32);
        drain(8'h30, 8'h4F, 32);
        check("t2_done_level", level_o, 0);

        // Simultaneous accept and advance.
        send(8'h50, 1'b0);
        sb_q.push_back('{win(8'h50, 8'h6F), 1'b0});
        step(1'b1, word(8'h60), 1'b1, 1'b1);
        check("t3_level", level_o, 31);
        drain(8'h51, 8'h6F, 31);
        check("t3_done_level", level_o, 0);

        // Asynchronous reset mid-row.
        send(8'h70, 1'b0);
        send(8'h80, 1'b0);
        for (int k = 0; k < 12; k++) adv_one(8'h70 + k, 8'h8F, 1'b0);
        check("t4_level", level_o, 20);
        rst_n_i = 1'b0;
        #2;
        check("t4_rst_valid", out_valid_o, 0);
        check("t4_rst_level", level_o, 0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        send(8'h90, 1'b1);
        check("t4_new_first", out_data_o, 56'h96959493929190);
        drain(8'h90, 8'h9F, 16);
        check("t4_done_level", level_o, 0);

        // Starved window: level 6 is the lowest sub-window level reachable in STREAM.
        send(8'hA0, 1'b0);
        for (int k = 0; k < 10; k++) adv_one(8'hA0 + k, 8'hBF, 1'b0);
        adv_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check("t5_level", level_o, 6);
        check("t5_valid", out_valid_o, 0);
        adv_i = 1'b0;
        send(8'hB0, 1'b1);
        check("t5_append_level", level_o, 22);
        check("t5_append_data", out_data_o, 56'hB0AFAEADACABAA);
        drain(8'hAA, 8'hBF, 22);
        check("t5_done_level", level_o, 0);
        check("t5_done_ready", in_ready_o, 1);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
